// File: rtl/calc_pkg.sv
// Shared calculator-datapath definitions: seven-segment glyph constants and the
// nibble-to-glyph lookup used by the display stage.
package calc_pkg;

    localparam int SEG_W = 7;

    // Segment bus bit order is {g,f,e,d,c,b,a}; all patterns are active-low.
    typedef enum logic [2:0] {
        SEG_A = 3'd0,
        SEG_B = 3'd1,
        SEG_C = 3'd2,
        SEG_D = 3'd3,
        SEG_E = 3'd4,
        SEG_F = 3'd5,
        SEG_G = 3'd6
    } seg_bit_e;

    localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    // Any nibble outside 0-9 renders as a dash so corrupt BCD is visible.
    function automatic logic [SEG_W-1:0] nibble_to_seg(input logic [3:0] nib);
        logic [SEG_W-1:0] pattern;
        case (nib)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_DASH;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD nibble to active-low seven-segment decoder with a blank
// override used for leading-zero suppression.
module bcd_to_seg
    import calc_pkg::*;
(
    input  logic [3:0]       digit,
    input  logic             blank,
    output logic [SEG_W-1:0] segments
);

    // Blank wins over the glyph; the anode is still driven by the caller.
    always_comb begin
        segments = SEG_BLANK;
        if (blank) begin
            segments = SEG_BLANK;
        end else begin
            segments = nibble_to_seg(digit);
        end
    end

endmodule

// File: rtl/bcd_seg_display.sv
// Multiplexed seven-segment driver: latches packed BCD results and scans them
// digit by digit with a guard cycle per slot and optional leading-zero blanking.
module bcd_seg_display
    import calc_pkg::*;
#(
    parameter int DECIMAL_DIGITS = 7,
    parameter int REFRESH_DIV    = 50000
) (
    input  logic                        i_Clock,
    input  logic                        i_Reset,
    input  logic [DECIMAL_DIGITS*4-1:0] i_BCD,
    input  logic                        i_DV,
    input  logic                        i_Blank_Leading,
    output logic [DECIMAL_DIGITS-1:0]   o_Anode,
    output logic [SEG_W-1:0]            o_Segments
);

    localparam int P_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int K_W = (DECIMAL_DIGITS > 1) ? $clog2(DECIMAL_DIGITS) : 1;
    localparam int BCD_W = DECIMAL_DIGITS * 4;

    localparam logic [P_W-1:0] P_LAST = P_W'(REFRESH_DIV - 1);
    localparam logic [K_W-1:0] K_LAST = K_W'(DECIMAL_DIGITS - 1);
    localparam logic [DECIMAL_DIGITS-1:0] ANODE_ONE = DECIMAL_DIGITS'(1);
    localparam logic [DECIMAL_DIGITS-1:0] ANODE_OFF = {DECIMAL_DIGITS{1'b1}};

    logic [BCD_W-1:0]          pending_r;
    logic [BCD_W-1:0]          shown_r;
    logic [P_W-1:0]            p_r;
    logic [K_W-1:0]            k_r;
    logic [DECIMAL_DIGITS-1:0] anode_r;
    logic [SEG_W-1:0]          seg_r;

    logic                      slot_end_s;
    logic [K_W-1:0]            k_next_s;
    logic [DECIMAL_DIGITS-1:0] nonzero_from_s;
    logic [3:0]                digit_s;
    logic                      blank_s;
    logic [SEG_W-1:0]          seg_s;

    assign slot_end_s = (p_r == P_LAST);

    // Next digit index, wrapping after the most significant digit.
    always_comb begin
        k_next_s = {K_W{1'b0}};
        if (k_r == K_LAST) begin
            k_next_s = {K_W{1'b0}};
        end else begin
            k_next_s = k_r + K_W'(1);
        end
    end

    // Capture, display latch, prescaler and digit index; a strobe coincident
    // with a slot boundary bypasses pending so the new value is not delayed.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            pending_r <= {BCD_W{1'b0}};
            shown_r   <= {BCD_W{1'b0}};
            p_r       <= {P_W{1'b0}};
            k_r       <= {K_W{1'b0}};
        end else begin
            if (i_DV) begin
                pending_r <= i_BCD;
            end
            if (slot_end_s) begin
                p_r     <= {P_W{1'b0}};
                k_r     <= k_next_s;
                shown_r <= i_DV ? i_BCD : pending_r;
            end else begin
                p_r <= p_r + P_W'(1);
            end
        end
    end

    // nonzero_from_s[i] is set when any nibble at position i or above is non-zero.
    always_comb begin : nz_scan
        logic acc;
        acc            = 1'b0;
        nonzero_from_s = {DECIMAL_DIGITS{1'b0}};
        for (int i = DECIMAL_DIGITS - 1; i >= 0; i--) begin
            acc               = acc | (|shown_r[4*i +: 4]);
            nonzero_from_s[i] = acc;
        end
    end

    assign digit_s = shown_r[{k_r, 2'b00} +: 4];
    assign blank_s = i_Blank_Leading & (k_r != {K_W{1'b0}}) & ~nonzero_from_s[k_r];

    bcd_to_seg u_dec (
        .digit    (digit_s),
        .blank    (blank_s),
        .segments (seg_s)
    );

    // Registered pins; the first output cycle of each slot is a dark guard cycle.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            anode_r <= ANODE_OFF;
            seg_r   <= SEG_BLANK;
        end else if (p_r == {P_W{1'b0}}) begin
            anode_r <= ANODE_OFF;
            seg_r   <= SEG_BLANK;
        end else begin
            anode_r <= ~(ANODE_ONE << k_r);
            seg_r   <= seg_s;
        end
    end

    assign o_Anode    = anode_r;
    assign o_Segments = seg_r;

endmodule
